s08_sci_uart: RTL and testbench

Memory-mapped serial communications interface for the MiniS08 CPU. It sits on the CPU data bus in the I/O window (addresses 0x04–0x07) and converts CPU byte writes into 8N1 frames on `txd`. It also assembles received 8N1 frames from `rxd` into a byte the CPU reads back. All logic runs on the 50 MHz board clock; CPU bus strobes are synchronous to that clock but held for many cycles, so the block acts on strobe edges, not levels.

---
 rtl/s08_sci_uart.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_s08_sci_uart.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s08_sci_uart.sv
`timescale 1ns/1ps
// s08_sci_uart: memory-mapped 8N1 UART for the MiniS08 I/O window
// (STATUS=4, DATA=5, CTRL=6), with a TX holding register and an RX holding byte.
// Ports: clk50, reset (async, active-high), din/dout (CPU data), sel/addr/read/write
// (CPU bus strobes, edge-detected), rxd (async serial in), txd (serial out).
// Build option: define SCI_TXFIFO_EN for a 4-entry TX FIFO instead of one register.
module s08_sci_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       sel,
  input  logic [2:0] addr,
  input  logic       read,
  input  logic       write,
  input  logic       rxd,
  output logic       txd
);

  localparam logic [15:0] BIT_END = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF    = 16'(BAUD_DIV / 2);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_st_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_e;

  // Bus strobes are held for many cycles; act on edges only.
  logic wr_lvl, ctl_lvl, rd_lvl;
  logic wr_q, ctl_q, rd_q;
  logic wr_ev, ctl_ev, rd_ev;

  assign wr_lvl  = sel & write & (addr == 3'd5);
  assign ctl_lvl = sel & write & (addr == 3'd6);
  assign rd_lvl  = sel & read  & (addr == 3'd5);

  assign wr_ev  = wr_lvl  & ~wr_q;
  assign ctl_ev = ctl_lvl & ~ctl_q;
  assign rd_ev  = ~rd_lvl & rd_q;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_q  <= 1'b0;
      ctl_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      wr_q  <= wr_lvl;
      ctl_q <= ctl_lvl;
      rd_q  <= rd_lvl;
    end
  end

  // TX state
  tx_st_e      tx_st_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_sh_q;
  logic        txd_q;
  logic        tx_end;
  logic        tx_pop;
  logic        tx_empty;
  logic        tdre;
  logic [7:0]  tx_head;
  logic        push_ok;

  assign tx_end = (tx_cnt_q == BIT_END);
  // Pop from IDLE, or at the end of STOP for gapless back-to-back frames.
  assign tx_pop = ~tx_empty &
                  ((tx_st_q == TX_IDLE) |
                   ((tx_st_q == TX_STOP) & tx_end));

`ifdef SCI_TXFIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] rp_q, wp_q;
  logic [2:0] fcnt_q;

  assign tx_empty = (fcnt_q == 3'd0);
  assign tdre     = ~fcnt_q[2];
  assign tx_head  = fifo_q[rp_q];
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok  = wr_ev & (~fcnt_q[2] | tx_pop);

  always_ff @(posedge clk50) begin
    if (push_ok)
      fifo_q[wp_q] <= din;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rp_q   <= 2'd0;
      wp_q   <= 2'd0;
      fcnt_q <= 3'd0;
    end else begin
      if (push_ok)
        wp_q <= wp_q + 2'd1;
      if (tx_pop)
        rp_q <= rp_q + 2'd1;
      fcnt_q <= fcnt_q + {2'b00, push_ok}
                       - {2'b00, tx_pop};
    end
  end
`else
  logic [7:0] hold_q;
  logic       full_q;

  assign tx_empty = ~full_q;
  assign tdre     = ~full_q;
  assign tx_head  = hold_q;
  assign push_ok  = wr_ev & (~full_q | tx_pop);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else begin
      if (push_ok)
        hold_q <= din;
      full_q <= push_ok | (full_q & ~tx_pop);
    end
  end
`endif

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= 16'd0;
      tx_bit_q <= 3'd0;
      tx_sh_q  <= 8'h00;
      txd_q    <= 1'b1;
    end else begin
      case (tx_st_q)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_st_q  <= TX_START;
            tx_cnt_q <= 16'd0;
            tx_sh_q  <= tx_head;
            txd_q    <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_end) begin
            tx_st_q  <= TX_DATA;
            tx_cnt_q <= 16'd0;
            tx_bit_q <= 3'd0;
            txd_q    <= tx_sh_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_end) begin
            tx_cnt_q <= 16'd0;
            if (tx_bit_q == 3'd7) begin
              tx_st_q <= TX_STOP;
              txd_q   <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              txd_q    <= tx_sh_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_end) begin
            tx_cnt_q <= 16'd0;
            if (tx_pop) begin
              tx_st_q <= TX_START;
              tx_sh_q <= tx_head;
              txd_q   <= 1'b0;
            end else begin
              tx_st_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

  assign txd = txd_q;

  // RX path
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_fall;
  rx_st_e      rx_st_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        rx_end;
  logic        rx_done;

  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign rx_end  = (rx_cnt_q == BIT_END);
  // rx_s2_q holds the stop-bit sample in this cycle.
  assign rx_done = (rx_st_q == RX_STOP) & rx_end;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= 16'd0;
      rx_bit_q <= 3'd0;
      rx_sh_q  <= 8'h00;
    end else begin
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= 16'd0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF) begin
            rx_cnt_q <= 16'd0;
            rx_bit_q <= 3'd0;
            // High at mid-start means a glitch, not a frame.
            rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_end) begin
            rx_cnt_q <= 16'd0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7)
              rx_st_q <= RX_STOP;
            else
              rx_bit_q <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_end) begin
            rx_cnt_q <= 16'd0;
            rx_st_q  <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // Receive status
  logic       rdrf_q, or_q, fe_q;
  logic       rdrf_d, or_d, fe_d;
  logic [7:0] rx_hold_q, rx_hold_d;

  always_comb begin
    rdrf_d    = rdrf_q;
    or_d      = or_q;
    fe_d      = fe_q;
    rx_hold_d = rx_hold_q;
    if (ctl_ev) begin
      or_d = 1'b0;
      fe_d = 1'b0;
    end
    if (rd_ev)
      rdrf_d = 1'b0;
    if (rx_done) begin
      // A read strobe ending this cycle makes room for the new byte.
      if (!rdrf_q || rd_ev) begin
        rx_hold_d = rx_sh_q;
        rdrf_d    = 1'b1;
        if (!rx_s2_q)
          fe_d = 1'b1;
      end else begin
        or_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rdrf_q    <= 1'b0;
      or_q      <= 1'b0;
      fe_q      <= 1'b0;
      rx_hold_q <= 8'h00;
    end else begin
      rdrf_q    <= rdrf_d;
      or_q      <= or_d;
      fe_q      <= fe_d;
      rx_hold_q <= rx_hold_d;
    end
  end

  logic tc;
  assign tc = (tx_st_q == TX_IDLE) & tx_empty;

  always_comb begin
    dout = 8'h00;
    case (addr)
      3'd4:    dout = {3'b000, tc, fe_q, or_q, tdre, rdrf_q};
      3'd5:    dout = rx_hold_q;
      default: dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_s08_sci_uart.sv
`timescale 1ns/1ps
// tb_s08_sci_uart: randomized self-checking bench for s08_sci_uart
// against a frame-level reference model (BAUD_DIV=8).
module tb_s08_sci_uart;

  localparam int BD = 8;
`ifdef SCI_TXFIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] dout;
  logic       sel;
  logic [2:0] addr;
  logic       rd;
  logic       wr;
  logic       rxd;
  logic       txd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model of receive-side status
  bit         m_rdrf, m_or, m_fe;
  logic [7:0] m_hold;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  s08_sci_uart #(.BAUD_DIV(BD)) dut (
    .clk50 (clk),
    .reset (rst),
    .din   (din),
    .dout  (dout),
    .sel   (sel),
    .addr  (addr),
    .read  (rd),
    .write (wr),
    .rxd   (rxd),
    .txd   (txd)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_status();
    return {3'b000, 1'b1, m_fe, m_or, 1'b1, m_rdrf};
  endfunction

  task automatic model_reset();
    m_rdrf = 0; m_or = 0; m_fe = 0; m_hold = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stopb);
    if (!m_rdrf) begin
      m_hold = b;
      m_rdrf = 1;
      if (!stopb) m_fe = 1;
    end else begin
      m_or = 1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    sel = 0; rd = 0; wr = 0; addr = 3'd0; din = 8'h00;
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk);
    sel = 1; rd = 0; wr = 0; addr = a;
    #1 v = dout;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    sel = 1; rd = 0; addr = a; din = d; wr = 1;
    @(negedge clk);
    wr = 0;
  endtask

  task automatic check_rx(input string nm);
    logic [7:0] v;
    peek(3'd4, v);
    checks++;
    if (v !== exp_status()) begin
      failures++;
      $display("FAIL %s status got=%h exp=%h", nm, v, exp_status());
    end
    peek(3'd5, v);
    checks++;
    if (v !== m_hold) begin
      failures++;
      $display("FAIL %s data got=%h exp=%h", nm, v, m_hold);
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input bit stopb);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (BD) @(negedge clk);
    end
    rxd = 1;
    repeat (2 * BD) @(negedge clk);
    model_frame(b, stopb);
  endtask

  task automatic read_data(input string nm);
    @(negedge clk);
    sel = 1; wr = 0; addr = 3'd5; rd = 1;
    @(negedge clk);
    #1;
    checks++;
    if (dout !== m_hold) begin
      failures++;
      $display("FAIL %s read got=%h exp=%h", nm, dout, m_hold);
    end
    @(negedge clk);
    rd = 0;
    m_rdrf = 0;
    repeat (2) @(negedge clk);
    check_rx(nm);
  endtask

  task automatic ctrl_write(input string nm);
    bus_write(3'd6, 8'($urandom));
    m_or = 0; m_fe = 0;
    repeat (2) @(negedge clk);
    check_rx(nm);
  endtask

  task automatic glitch(input string nm);
    @(negedge clk);
    rxd = 0;
    repeat (2) @(negedge clk);
    rxd = 1;
    repeat (3 * BD) @(negedge clk);
    check_rx(nm);
  endtask

  // Decode one frame from txd by sampling bit centres.
  task automatic rx_tx_frame(output logic [7:0] b, output int t,
                             output bit ok);
    bit found;
    logic st, sp;
    found = 0; ok = 0; b = 8'h00; t = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick(1);
      if (txd === 1'b0) found = 1;
    end
    if (!found) return;
    t = cyc;
    tick(BD / 2);
    st = txd;
    for (int i = 0; i < 8; i++) begin
      tick(BD);
      b[i] = txd;
    end
    tick(BD);
    sp = txd;
    ok = (st === 1'b0) && (sp === 1'b1);
  endtask

  task automatic test_reset();
    logic [7:0] v, e;
    rst = 1; rxd = 1; idle_bus();
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("FAIL reset_txd got=%b exp=1", txd);
    end
    for (int a = 0; a < 8; a++) begin
      peek(3'(a), v);
      e = (a == 4) ? 8'h12 : 8'h00;
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL reset_addr%0d got=%h exp=%h", a, v, e);
      end
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_rx("post_reset");
  endtask

  task automatic test_tx_single(input logic [7:0] b);
    logic [9:0] fr;
    logic e;
    fr = {1'b1, b, 1'b0};
    @(negedge clk);
    sel = 1; rd = 0; addr = 3'd5; din = b; wr = 1;
    for (int k = 1; k <= 84; k++) begin
      tick(1);
      e = (k < 2 || k >= 82) ? 1'b1 : fr[(k - 2) / BD];
      checks++;
      if (txd !== e) begin
        failures++;
        $display("FAIL tx_%h_cyc%0d txd got=%b exp=%b", b, k, txd, e);
      end
      if (k == 81) begin
        checks++;
        if (dout[4] !== 1'b0) begin
          failures++;
          $display("FAIL tx_%h tc_busy got=%b exp=0", b, dout[4]);
        end
      end
      if (k == 82) begin
        checks++;
        if (dout !== exp_status()) begin
          failures++;
          $display("FAIL tx_%h tc_done got=%h exp=%h", b, dout, exp_status());
        end
      end
      if (k == 2) begin
        wr = 0; addr = 3'd4;
      end
    end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    logic [7:0] v;
    logic [7:0] got;
    int t, tprev;
    bit ok;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    tprev = 0;
    fork
      begin
        bus_write(3'd5, bytes[0]);
        repeat (5) @(negedge clk);
        for (int i = 1; i <= CAP + 1; i++)
          bus_write(3'd5, bytes[i]);
        peek(3'd4, v);
        checks++;
        if (v[1] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_tdre_full got=%b exp=0", v[1]);
        end
      end
      begin
        for (int f = 0; f <= CAP; f++) begin
          rx_tx_frame(got, t, ok);
          checks++;
          if (!ok || got !== bytes[f]) begin
            failures++;
            $display("FAIL b2b_frame%0d got=%h ok=%0d exp=%h",
                     f, got, ok, bytes[f]);
          end
          if (f > 0) begin
            checks++;
            if (t - tprev != 10 * BD) begin
              failures++;
              $display("FAIL b2b_gap%0d got=%0d exp=%0d",
                       f, t - tprev, 10 * BD);
            end
          end
          tprev = t;
        end
      end
    join
    // The dropped byte must never appear: line stays idle until TC.
    v = 8'h00;
    for (int i = 0; i < 300; i++) begin
      peek(3'd4, v);
      if (v === exp_status()) break;
      checks++;
      if (txd !== 1'b1) begin
        failures++;
        $display("FAIL b2b_extra_frame txd got=%b exp=1", txd);
        break;
      end
    end
    checks++;
    if (v !== exp_status()) begin
      failures++;
      $display("FAIL b2b_tc got=%h exp=%h", v, exp_status());
    end
    idle_bus();
  endtask

  task automatic test_rx_directed();
    drive_rx(8'h3C, 1);
    check_rx("rx_3c");
    read_data("rx_3c_read");
    drive_rx(8'h11, 1);
    drive_rx(8'h22, 1);
    check_rx("rx_overrun");
    ctrl_write("rx_ctrl_clear");
    read_data("rx_11_read");
    drive_rx(8'h55, 0);
    check_rx("rx_framing");
    glitch("rx_glitch");
    ctrl_write("rx_fe_clear");
    read_data("rx_55_read");
  endtask

  task automatic test_rx_random();
    int op;
    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        drive_rx(8'($urandom), $urandom_range(0, 3) != 0);
        check_rx("rx_rand_frame");
      end else if (op == 3) begin
        read_data("rx_rand_read");
      end else if (op == 4) begin
        ctrl_write("rx_rand_ctrl");
      end else begin
        glitch("rx_rand_glitch");
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] v;
    bit found;
    found = 0;
    bus_write(3'd5, 8'($urandom) | 8'h01);
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (txd === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midtx_start got=timeout exp=txd_low");
    end
    // Partial RX frame in flight too; it must be discarded.
    rxd = 0;
    tick(2 * BD);
    #2 rst = 1;
    #1;
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("FAIL midtx_async txd got=%b exp=1", txd);
    end
    rxd = 1;
    idle_bus();
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    repeat (12 * BD) @(negedge clk);
    peek(3'd4, v);
    checks++;
    if (v !== 8'h12) begin
      failures++;
      $display("FAIL midtx_status got=%h exp=12", v);
    end
    check_rx("midtx_rx_discard");
  endtask

  initial begin
    test_reset();
    test_tx_single(8'hA5);
    for (int i = 0; i < 3; i++)
      test_tx_single(8'($urandom));
    test_back_to_back();
    test_rx_directed();
    test_rx_random();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
